// File: rtl/vram_port_arbiter_if.sv
// Bundle of requester, clear-engine and RAM port B signals for vram_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              clr_start;
    logic [DATA_W-1:0] clr_word;
    logic              clr_busy;

    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic              we_b;
    logic [DATA_W-1:0] q_b;

    modport slave (
        input  clr_start, clr_word,
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  q_b,
        output clr_busy,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output addr_b, data_b, we_b
    );

    modport master (
        output clr_start, clr_word,
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output q_b,
        input  clr_busy,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  addr_b, data_b, we_b
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter for VRAM port B shared by two requesters plus a fill engine.
// All RAM-side signals are registered; reads return with a per-requester strobe.
module vram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    vram_port_arbiter_if.slave   bus
);
    localparam int PIPE_D = 1 + RD_LAT;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        CLEAR
    } state_t;

    state_t            state, state_nxt;
    logic              last, last_nxt;

    logic [ADDR_W:0]   clr_cnt;
    logic [ADDR_W:0]   clr_cnt_nxt;
    logic [DATA_W-1:0] clr_word_q;
    logic              clr_busy;
    logic              clr_accept;
    logic              clr_done;

    logic              arb_ok;
    logic              pick0;
    logic              gnt0, gnt1;
    logic              rd_gnt;

    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              we_q, we_nxt;

    logic [PIPE_D-1:0] pv;
    logic [PIPE_D-1:0] pid;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign clr_busy    = (state == CLEAR);
    assign clr_accept  = bus.clr_start & ~clr_busy;
    // Counter carries one extra bit so the sweep end is seen at 2^ADDR_W.
    assign clr_cnt_nxt = clr_cnt + (ADDR_W+1)'(1);
    assign clr_done    = clr_cnt_nxt[ADDR_W];

    assign arb_ok = ~clr_busy & ~clr_accept & ~rst;
    assign pick0  = bus.r0_req & (~bus.r1_req | last);
    assign gnt0   = pick0 & arb_ok;
    assign gnt1   = bus.r1_req & ~pick0 & arb_ok;
    assign rd_gnt = (gnt0 & ~bus.r0_we) | (gnt1 & ~bus.r1_we);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        we_nxt    = 1'b0;
        case (state)
            CLEAR: begin
                we_nxt   = 1'b1;
                addr_nxt = clr_cnt[ADDR_W-1:0];
                data_nxt = clr_word_q;
                if (clr_done)
                    state_nxt = IDLE;
            end
            default: begin
                if (clr_accept)
                    state_nxt = CLEAR;
                else if (gnt0 | gnt1)
                    state_nxt = SERVE;
                else
                    state_nxt = IDLE;

                if (gnt0) begin
                    we_nxt   = bus.r0_we;
                    addr_nxt = bus.r0_addr;
                    data_nxt = bus.r0_wdata;
                    last_nxt = 1'b0;
                end else if (gnt1) begin
                    we_nxt   = bus.r1_we;
                    addr_nxt = bus.r1_addr;
                    data_nxt = bus.r1_wdata;
                    last_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            clr_cnt    <= '0;
            clr_word_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            pv         <= '0;
            pid        <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            we_q   <= we_nxt;

            if (clr_accept) begin
                clr_word_q <= bus.clr_word;
                clr_cnt    <= '0;
            end else if (clr_busy) begin
                clr_cnt <= clr_cnt_nxt;
            end

            // Tag pipeline: the exit stage lines up with q_b for the tagged read.
            pv  <= {pv[PIPE_D-2:0], rd_gnt};
            pid <= {pid[PIPE_D-2:0], gnt1};

            rvalid0_q <= pv[RD_LAT] & ~pid[RD_LAT];
            rvalid1_q <= pv[RD_LAT] &  pid[RD_LAT];
            if (pv[RD_LAT] & ~pid[RD_LAT])
                rdata0_q <= bus.q_b;
            if (pv[RD_LAT] & pid[RD_LAT])
                rdata1_q <= bus.q_b;
        end
    end

    assign bus.clr_busy  = clr_busy;
    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
    assign bus.addr_b    = addr_q;
    assign bus.data_b    = data_q;
    assign bus.we_b      = we_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a write-first RAM model on port B.
// Drivers push expected bus writes / read returns; a negedge monitor pops and compares.
module tb_vram_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int unsigned       cyc;
    } wr_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int unsigned       cyc;
    } rd_t;

    localparam logic [31:0] PAT [8] = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                        32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    wr_t exp_wr [$];
    rd_t exp_rd0 [$];
    rd_t exp_rd1 [$];

    logic [DATA_W-1:0] mem [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Port B of the RAM: write-first, one cycle read latency.
    always @(posedge clk) begin
        if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
        bus.q_b <= bus.we_b ? bus.data_b : mem[bus.addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon_rd(input int id, input logic [31:0] data);
        rd_t r;
        n_vec++;
        if ((id == 0 && exp_rd0.size() == 0) || (id == 1 && exp_rd1.size() == 0)) begin
            n_bad++;
            $display("FAIL r%0d_rvalid: unexpected strobe data %h at cycle %0d, expected none", id, data, cyc);
        end else begin
            r = (id == 0) ? exp_rd0.pop_front() : exp_rd1.pop_front();
            if (r.data !== data || r.cyc != cyc) begin
                n_bad++;
                $display("FAIL r%0d_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                         id, data, cyc, r.data, r.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (bus.we_b === 1'b1) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
                n_bad++;
                $display("FAIL bus_write: unexpected addr %h data %h at cycle %0d, expected none",
                         bus.addr_b, bus.data_b, cyc);
            end else begin
                w = exp_wr.pop_front();
                if (w.addr !== bus.addr_b || w.data !== bus.data_b || w.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL bus_write: got addr %h data %h cycle %0d, expected addr %h data %h cycle %0d",
                             bus.addr_b, bus.data_b, cyc, w.addr, w.data, w.cyc);
                end
            end
        end
        if (bus.r0_rvalid === 1'b1) mon_rd(0, bus.r0_rdata);
        if (bus.r1_rvalid === 1'b1) mon_rd(1, bus.r1_rdata);
    end

    task automatic set_req(input int id, input logic req, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (id == 0) begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
    endtask

    // Called just after a rising edge; returns just after the edge ending the grant cycle.
    task automatic do_access(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                             input bit push, output int unsigned gcyc);
        bit  got;
        wr_t e;
        rd_t r;
        got  = 1'b0;
        gcyc = 0;
        set_req(id, 1'b1, we, addr, wdata);
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            if ((id == 0 ? bus.r0_gnt : bus.r1_gnt) === 1'b1) begin
                got  = 1'b1;
                gcyc = cyc;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_timeout_r%0d: got no grant in 6000 cycles, expected a grant", id);
        end else if (push) begin
            if (we) begin
                e.addr = addr; e.data = wdata; e.cyc = gcyc + 1;
                exp_wr.push_back(e);
            end else begin
                r.data = exp_rdata; r.cyc = gcyc + 2 + RD_LAT;
                if (id == 0) exp_rd0.push_back(r); else exp_rd1.push_back(r);
            end
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, we, addr, wdata);
    endtask

    task automatic do_clear(input logic [DATA_W-1:0] word, input int unsigned n_writes,
                            input int unsigned abort_at, input bit poke, output int unsigned s);
        wr_t         e;
        int unsigned nbusy, bad;
        bit          done, aborted;
        bus.clr_start = 1'b1;
        bus.clr_word  = word;
        @(negedge clk);
        s = cyc;
        check("clr_busy_at_accept", 32'(bus.clr_busy), 32'd0);
        check("no_grant_at_accept", 32'({bus.r0_gnt, bus.r1_gnt}), 32'd0);
        for (int unsigned k = 0; k < n_writes; k++) begin
            e.addr = ADDR_W'(k); e.data = word; e.cyc = s + 2 + k;
            exp_wr.push_back(e);
        end
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        bus.clr_word  = ~word;
        nbusy = 0; bad = 0; done = 1'b0; aborted = 1'b0;
        for (int i = 0; i < 6000 && !done && !aborted; i++) begin
            if (abort_at != 0 && cyc == s + abort_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end else begin
                bus.clr_start = poke && (cyc == s + 10);
                @(negedge clk);
                if (bus.clr_busy !== 1'b1) done = 1'b1;
                else begin
                    nbusy++;
                    if (bus.r0_gnt | bus.r1_gnt) bad++;
                    @(posedge clk); #1;
                end
            end
        end
        bus.clr_start = 1'b0;
        if (!aborted) begin
            check("clr_busy_cycles", nbusy, DEPTH);
            check("grants_during_clear", bad, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_clr_busy"},  32'(bus.clr_busy),  32'd0);
        check({name, "_r0_gnt"},    32'(bus.r0_gnt),    32'd0);
        check({name, "_r1_gnt"},    32'(bus.r1_gnt),    32'd0);
        check({name, "_r0_rvalid"}, 32'(bus.r0_rvalid), 32'd0);
        check({name, "_r1_rvalid"}, 32'(bus.r1_rvalid), 32'd0);
        check({name, "_r0_rdata"},  bus.r0_rdata,       32'd0);
        check({name, "_r1_rdata"},  bus.r1_rdata,       32'd0);
        check({name, "_addr_b"},    32'(bus.addr_b),    32'd0);
        check({name, "_data_b"},    bus.data_b,         32'd0);
        check({name, "_we_b"},      32'(bus.we_b),      32'd0);
    endtask

    initial begin
        int unsigned g, g0, g0a, g0b, g1a, g1b, c, s;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.clr_start = 1'b0;
        bus.clr_word  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write then read-after-write, back to back.
        do_access(0, 1'b1, 12'h123, 32'h44E9_4E90, '0, 1'b1, g0);
        do_access(0, 1'b0, 12'h123, '0, 32'h44E9_4E90, 1'b1, g);
        check("raw_back_to_back", g, g0 + 1);

        // Preload 0..7 from r0, then pipelined reads from r1 (leaves last = r1).
        for (int i = 0; i < 8; i++)
            do_access(0, 1'b1, ADDR_W'(i), PAT[i], '0, 1'b1, g);
        for (int i = 0; i < 8; i++) begin
            do_access(1, 1'b0, ADDR_W'(i), '0, PAT[i], 1'b1, g);
            if (i == 0) g0 = g;
            else check("pipelined_read_grant", g, g0 + i);
        end

        // Contention: both requesters hold req for two accesses each.
        c = cyc;
        fork
            begin
                do_access(0, 1'b1, 12'h010, 32'hA000_0010, '0, 1'b1, g0a);
                do_access(0, 1'b1, 12'h012, 32'hA000_0012, '0, 1'b1, g0b);
            end
            begin
                do_access(1, 1'b1, 12'h011, 32'hB000_0011, '0, 1'b1, g1a);
                do_access(1, 1'b1, 12'h013, 32'hB000_0013, '0, 1'b1, g1b);
            end
        join
        check("rr_grant0_r0", g0a, c);
        check("rr_grant1_r1", g1a, c + 1);
        check("rr_grant2_r0", g0b, c + 2);
        check("rr_grant3_r1", g1b, c + 3);

        // Full clear while r0 is requesting in the same cycle.
        fork
            do_clear(32'h2000_0000, DEPTH, 0, 1'b0, s);
            do_access(0, 1'b1, 12'h055, 32'hCAFE_F00D, '0, 1'b1, g);
        join
        check("r0_gnt_after_clear", g, s + DEPTH + 1);
        do_access(0, 1'b0, 12'hFFF, '0, 32'h2000_0000, 1'b1, g);
        do_access(1, 1'b0, 12'h055, '0, 32'hCAFE_F00D, 1'b1, g);

        // Read granted at S-1, clear at S, ignored clr_start at S+10.
        do_access(0, 1'b0, 12'h055, '0, 32'hCAFE_F00D, 1'b1, g);
        do_clear(32'h0000_0707, DEPTH, 0, 1'b1, s);
        check("clear_after_read_cycle", s, g + 1);
        do_access(1, 1'b0, 12'h800, '0, 32'h0000_0707, 1'b1, g);

        // Reset at clear cycle 100; r0 was granted last so the reset of `last` is visible.
        do_access(0, 1'b0, 12'h000, '0, 32'h0000_0707, 1'b1, g);
        do_clear(32'h5A5A_5A5A, 99, 100, 1'b0, s);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        c = cyc;
        fork
            do_access(0, 1'b0, 12'h010, '0, 32'h5A5A_5A5A, 1'b1, g0a);
            do_access(1, 1'b0, 12'hFFF, '0, 32'h0000_0707, 1'b1, g1a);
        join
        check("post_reset_r0_first", g0a, c);
        check("post_reset_r1_second", g1a, c + 1);

        // Reset with a read in flight: no strobe may follow.
        repeat (4) @(posedge clk);
        #1;
        do_access(1, 1'b0, 12'h011, '0, '0, 1'b0, g);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rd_flight");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_rvalid_after_reset", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'd0);
        end

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("pending_writes", exp_wr.size(), 32'd0);
        check("pending_r0_reads", exp_rd0.size(), 32'd0);
        check("pending_r1_reads", exp_rd1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares port B of the 4096 x 32 character/attribute RAM that the VGA text pipeline scans out on port A. Two requesters (e.g. a test pattern writer and a host/UART writer) issue single-word reads and writes; a built-in clear engine fills the whole RAM with one word on command. Arbitration is round-robin, all RAM-side signals are registered, and read data is returned with a per-requester valid strobe.

## Interface
- ADDR_W, 12, RAM word address width; the clear engine sweeps 2^ADDR_W words.
- DATA_W, 32, RAM word width; the packing {char 8, attr 6, char 8, attr 10} is opaque to this block.
- RD_LAT, 1, cycles from `addr_b` sampled by the RAM to `q_b` valid; legal values 1 or 2.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- clr_start  in  1  one-cycle request to fill the RAM.
- clr_word  in  DATA_W  fill value, sampled in the cycle `clr_start` is accepted.
- clr_busy  out  1  clear in progress.
- rN_req  in  1  requester N (N = 0, 1) access request; held until granted.
- rN_we  in  1  1 = write, 0 = read; held with `rN_req`.
- rN_addr  in  ADDR_W  word address; held with `rN_req`.
- rN_wdata  in  DATA_W  write data; held with `rN_req`.
- rN_gnt  out  1  combinational; request accepted this cycle.
- rN_rvalid  out  1  one-cycle strobe; `rN_rdata` is valid.
- rN_rdata  out  DATA_W  read data, registered.
- addr_b  out  ADDR_W  RAM port B address, registered.
- data_b  out  DATA_W  RAM port B write data, registered.
- we_b  out  1  RAM port B write enable, registered.
- q_b  in  DATA_W  RAM port B read data.

## Operation
- States: IDLE (no bus activity), SERVE (a grant was issued last cycle), CLEAR. IDLE and SERVE differ only in bus drive; arbitration is identical in both.
- Grant: `rN_gnt = rN_req & ~clr_busy & ~clr_accept & ~rst`. At most one grant per cycle.
- Round-robin: `last` pointer resets to 1, so r0 wins the first contention. When both request, the requester not equal to `last` wins. `last` updates on every grant, including uncontested ones.
- A granted access is registered onto `addr_b`/`data_b`/`we_b` the next cycle. With no grant, `we_b` = 0 and `addr_b`/`data_b` hold their last values.
- A read grant pushes a tag (requester id) into a (1+RD_LAT)-deep valid pipeline. On exit, the pipeline registers `q_b` into `rN_rdata` and pulses `rN_rvalid` for that requester. `rN_rdata` holds its value between strobes.
- Clear: `clr_accept = clr_start & ~clr_busy`. On accept, `clr_word` is latched and the counter is set to 0. The engine then writes the latched word to addresses 0 .. 2^ADDR_W-1 in order, one per cycle. `clr_start` while busy is ignored.
- Reads granted before a clear still complete and strobe during CLEAR.
- Address arithmetic is ADDR_W bits. The clear counter is ADDR_W+1 bits so the end is detected at 2^ADDR_W, without relying on wrap.

## Timing
- Reset values: `clr_busy` 0, `rN_gnt` 0, `rN_rvalid` 0, `rN_rdata` 0, `addr_b` 0, `data_b` 0, `we_b` 0, `last` 1, pipeline empty, state IDLE.
- Write granted in cycle T: `we_b` = 1 with its address and data in cycle T+1; the RAM writes at the end of T+1.
- Read granted in cycle T: `addr_b` presented in T+1, `q_b` valid in T+1+RD_LAT, `rN_rvalid` high in T+2+RD_LAT. Latency is 3 cycles for RD_LAT=1.
- Back-to-back grants are allowed every cycle, giving full bus throughput.
- Read after write to the same address, granted on consecutive cycles, returns the new data (the RAM is write-first on port B).
- Clear accepted in cycle S:
  - `clr_busy` is high in cycles S+1 .. S+2^ADDR_W.
  - Write k is on the bus in cycle S+2+k.
  - No grants in cycles S .. S+2^ADDR_W.
  - Grants resume in cycle S+1+2^ADDR_W; the first granted access reaches the bus after the final clear write, so there is no collision.
- `clr_start` and requests in the same idle cycle: the clear wins and no grant is issued.
- Reset mid-operation (including mid-clear):
  - All outputs return to reset values on the next edge.
  - In-flight reads are dropped without `rvalid`.
  - The clear is aborted; the RAM contents are left partially filled.

## Test plan
- Single write then read: r0 writes 0x44E94E90 to 0x123, then reads 0x123. Required: `we_b` pulse at grant+1, and `r0_rvalid` at read grant+3 with `r0_rdata` = 0x44E94E90.
- Contention: r0 and r1 both hold `req` for 4 cycles. Required grant sequence r0, r1, r0, r1; `we_b`/`addr_b` alternate accordingly with no idle gaps.
- Pipelined reads: r1 reads 0x000 .. 0x007 back-to-back. Required: 8 consecutive `r1_rvalid` cycles with data in address order.
- Clear: `clr_start` with `clr_word` = 0x20000000 while r0 is requesting. Required:
  - `clr_busy` high for exactly 4096 cycles.
  - Addresses 0 .. 0xFFF are written in order.
  - `r0_gnt` stays low until `clr_busy` falls; a later readback of 0xFFF returns 0x20000000.
- Clear with an in-flight read: grant a read at S-1, then clear at S. Required: `rvalid` is still delivered, and `clr_start` pulses at S+10 are ignored.
- Reset at clear cycle 100 with a read in flight. Required:
  - All outputs are 0 next cycle and no `rvalid` is issued.
  - A subsequent r0 request is granted immediately.
  - `last` resets, so r0 wins the next contention.
